// File: rtl/lpddr5x_req_queue.sv
// rtl/lpddr5x_req_queue.sv - in-order LPDDR5x request queue with tagged, credit-throttled read returns
//
// Buffers client read/write requests in an in-order FIFO and issues them on
// the controller command port. Read data from the controller carries no tag
// and cannot be stalled, so every read issue reserves a credit that is only
// returned when the client accepts the matching response.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  client request port (valid/ready, addr, wdata, write, tag)
//   mem_cmd_*              command port to the controller (valid/ready)
//   mem_rsp_valid_i/rdata  untagged fixed-latency read data from the controller
//   rsp_*                  tagged read response to the client (valid/ready)
//   queue_count_o          request FIFO occupancy
//   rd_inflight_o          reads issued and not yet accepted by the client
//   err_unexp_rsp_o        sticky flag: read data arrived with no read pending
module lpddr5x_req_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 8,
    parameter int MAX_RD     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [DATA_WIDTH-1:0]       req_wdata_i,
    input  logic                        req_write_i,
    input  logic [TAG_WIDTH-1:0]        req_tag_i,
    output logic                        mem_cmd_valid_o,
    input  logic                        mem_cmd_ready_i,
    output logic [ADDR_WIDTH-1:0]       mem_cmd_addr_o,
    output logic [DATA_WIDTH-1:0]       mem_cmd_wdata_o,
    output logic                        mem_cmd_write_o,
    input  logic                        mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]       mem_rsp_rdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic [TAG_WIDTH-1:0]        rsp_tag_o,
    output logic [$clog2(DEPTH):0]      queue_count_o,
    output logic [$clog2(MAX_RD):0]     rd_inflight_o,
    output logic                        err_unexp_rsp_o
);

    localparam int QPW = $clog2(DEPTH);
    localparam int QCW = QPW + 1;
    localparam int RCW = $clog2(MAX_RD) + 1;
    localparam int RIW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;

    localparam logic [QCW-1:0] DEPTH_C  = QCW'(DEPTH);
    localparam logic [RCW-1:0] MAX_RD_C = RCW'(MAX_RD);
    localparam logic [RIW-1:0] LAST_IDX = RIW'(MAX_RD - 1);

    // MAX_RD need not be a power of two, so the small rings wrap explicitly.
    function automatic logic [RIW-1:0] ring_inc(input logic [RIW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // ---------------- request FIFO ----------------
    logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] q_wdata [DEPTH];
    logic                  q_write [DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag   [DEPTH];

    logic [QCW-1:0] q_wr_ptr, q_rd_ptr, q_count;
    logic [QPW-1:0] q_head;
    logic           q_empty, q_push, q_pop, head_write, credit_ok, rd_issue;

    logic [RCW-1:0] rd_inflight;

    assign q_count     = q_wr_ptr - q_rd_ptr;
    assign q_empty     = (q_count == '0);
    assign q_head      = q_rd_ptr[QPW-1:0];
    assign req_ready_o = (q_count != DEPTH_C);
    assign q_push      = req_valid_i && req_ready_o;

    // A read at the head without a credit stalls everything behind it.
    assign head_write      = q_write[q_head];
    assign credit_ok       = (rd_inflight < MAX_RD_C);
    assign mem_cmd_valid_o = !q_empty && (head_write || credit_ok);
    assign q_pop           = mem_cmd_valid_o && mem_cmd_ready_i;
    assign rd_issue        = q_pop && !head_write;

    // Fields read as zero while empty so the port is clean out of reset.
    assign mem_cmd_addr_o  = q_empty ? '0   : q_addr[q_head];
    assign mem_cmd_wdata_o = q_empty ? '0   : q_wdata[q_head];
    assign mem_cmd_write_o = q_empty ? 1'b0 : head_write;

    always_ff @(posedge clk_i) begin
        if (q_push) begin
            q_addr[q_wr_ptr[QPW-1:0]]  <= req_addr_i;
            q_wdata[q_wr_ptr[QPW-1:0]] <= req_wdata_i;
            q_write[q_wr_ptr[QPW-1:0]] <= req_write_i;
            q_tag[q_wr_ptr[QPW-1:0]]   <= req_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
        end else begin
            if (q_push) q_wr_ptr <= q_wr_ptr + 1'b1;
            if (q_pop)  q_rd_ptr <= q_rd_ptr + 1'b1;
        end
    end

    // ---------------- pending-tag FIFO ----------------
    // Holds tags of reads issued whose data has not yet come back.
    logic [TAG_WIDTH-1:0] pt_tag [MAX_RD];
    logic [RIW-1:0]       pt_wr, pt_rd;
    logic [RCW-1:0]       pt_count;
    logic                 rsp_push;

    assign rsp_push = mem_rsp_valid_i && (pt_count != '0);

    always_ff @(posedge clk_i) begin
        if (rd_issue) pt_tag[pt_wr] <= q_tag[q_head];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pt_wr    <= '0;
            pt_rd    <= '0;
            pt_count <= '0;
        end else begin
            if (rd_issue) pt_wr <= ring_inc(pt_wr);
            if (rsp_push) pt_rd <= ring_inc(pt_rd);
            case ({rd_issue, rsp_push})
                2'b10:   pt_count <= pt_count + 1'b1;
                2'b01:   pt_count <= pt_count - 1'b1;
                default: pt_count <= pt_count;
            endcase
        end
    end

    // ---------------- response FIFO ----------------
    // Cannot overflow: its occupancy plus pending tags never exceeds rd_inflight.
    logic [DATA_WIDTH-1:0] rf_data [MAX_RD];
    logic [TAG_WIDTH-1:0]  rf_tag  [MAX_RD];
    logic [RIW-1:0]        rf_wr, rf_rd;
    logic [RCW-1:0]        rf_count;
    logic                  rsp_pop;

    assign rsp_valid_o = (rf_count != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? rf_data[rf_rd] : '0;
    assign rsp_tag_o   = rsp_valid_o ? rf_tag[rf_rd]  : '0;

    always_ff @(posedge clk_i) begin
        if (rsp_push) begin
            rf_data[rf_wr] <= mem_rsp_rdata_i;
            rf_tag[rf_wr]  <= pt_tag[pt_rd];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_wr    <= '0;
            rf_rd    <= '0;
            rf_count <= '0;
        end else begin
            if (rsp_push) rf_wr <= ring_inc(rf_wr);
            if (rsp_pop)  rf_rd <= ring_inc(rf_rd);
            case ({rsp_push, rsp_pop})
                2'b10:   rf_count <= rf_count + 1'b1;
                2'b01:   rf_count <= rf_count - 1'b1;
                default: rf_count <= rf_count;
            endcase
        end
    end

    // ---------------- read credits and error flag ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_inflight     <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            case ({rd_issue, rsp_pop})
                2'b10:   rd_inflight <= rd_inflight + 1'b1;
                2'b01:   rd_inflight <= rd_inflight - 1'b1;
                default: rd_inflight <= rd_inflight;
            endcase
            if (mem_rsp_valid_i && (pt_count == '0)) err_unexp_rsp_o <= 1'b1;
        end
    end

    assign queue_count_o = q_count;
    assign rd_inflight_o = rd_inflight;

endmodule

// File: tb/tb_lpddr5x_req_queue.sv
// tb/tb_lpddr5x_req_queue.sv - self-checking bench for lpddr5x_req_queue
module tb_lpddr5x_req_queue;

    localparam int AW     = 32;
    localparam int DW     = 512;
    localparam int TW     = 4;
    localparam int DEPTH  = 8;
    localparam int MAX_RD = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     req_valid_i = 1'b0;
    logic                     req_ready_o;
    logic [AW-1:0]            req_addr_i = '0;
    logic [DW-1:0]            req_wdata_i = '0;
    logic                     req_write_i = 1'b0;
    logic [TW-1:0]            req_tag_i = '0;
    logic                     mem_cmd_valid_o;
    logic                     mem_cmd_ready_i = 1'b0;
    logic [AW-1:0]            mem_cmd_addr_o;
    logic [DW-1:0]            mem_cmd_wdata_o;
    logic                     mem_cmd_write_o;
    logic                     mem_rsp_valid_i = 1'b0;
    logic [DW-1:0]            mem_rsp_rdata_i = '0;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i = 1'b0;
    logic [DW-1:0]            rsp_rdata_o;
    logic [TW-1:0]            rsp_tag_o;
    logic [$clog2(DEPTH):0]   queue_count_o;
    logic [$clog2(MAX_RD):0]  rd_inflight_o;
    logic                     err_unexp_rsp_o;

    lpddr5x_req_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .MAX_RD(MAX_RD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_write_i(req_write_i), .req_tag_i(req_tag_i),
        .mem_cmd_valid_o(mem_cmd_valid_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_wdata_o(mem_cmd_wdata_o),
        .mem_cmd_write_o(mem_cmd_write_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_tag_o(rsp_tag_o), .queue_count_o(queue_count_o),
        .rd_inflight_o(rd_inflight_o), .err_unexp_rsp_o(err_unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
        logic [TW-1:0] tag;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_t;

    // Reference model: plain queues of what the client has handed over.
    cmd_t          exp_cmd[$];
    logic [TW-1:0] pend_tags[$];
    rsp_t          exp_rsp[$];
    logic [TW-1:0] seen_tags[$];
    int            inflight = 0;
    bit            exp_err = 0;
    bit            ret_next = 0;
    bit            spur = 0;

    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    bit            req_acc = 0;
    int            acc_cyc = 0;
    int            acc_cnt = 0;
    int            cmd_cnt = 0;
    int            rsp_cnt = 0;
    int            last_rsp_cyc = 0;
    logic [DW-1:0] last_rsp_data = '0;
    logic [TW-1:0] last_rsp_tag = '0;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // One clock: check outputs mid-cycle against the model, apply the
    // handshakes that occur at the coming edge, then act as the controller.
    task automatic tick();
        bit   ev;
        cmd_t c;
        rsp_t r;
        @(negedge clk_i);
        ev = (exp_cmd.size() != 0) && (exp_cmd[0].write || inflight < MAX_RD);
        chk("queue_count", queue_count_o, exp_cmd.size());
        chk("req_ready", req_ready_o, exp_cmd.size() != DEPTH);
        chk("rd_inflight", rd_inflight_o, inflight);
        chk("cmd_valid", mem_cmd_valid_o, ev);
        if (ev) begin
            chk("cmd_addr", mem_cmd_addr_o, exp_cmd[0].addr);
            chk("cmd_write", mem_cmd_write_o, exp_cmd[0].write);
            if (exp_cmd[0].write) chk("cmd_wdata", mem_cmd_wdata_o, exp_cmd[0].wdata);
        end
        chk("rsp_valid", rsp_valid_o, exp_rsp.size() != 0);
        if (exp_rsp.size() != 0) begin
            chk("rsp_rdata", rsp_rdata_o, exp_rsp[0].data);
            chk("rsp_tag", rsp_tag_o, exp_rsp[0].tag);
        end
        chk("err_unexp", err_unexp_rsp_o, exp_err);

        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            inflight--;
            rsp_cnt++;
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_rdata_o;
            last_rsp_tag  = rsp_tag_o;
            seen_tags.push_back(rsp_tag_o);
        end
        if (mem_cmd_valid_o && mem_cmd_ready_i && exp_cmd.size() != 0) begin
            c = exp_cmd.pop_front();
            cmd_cnt++;
            if (!c.write) begin
                inflight++;
                pend_tags.push_back(c.tag);
                ret_next = 1;
            end
        end
        req_acc = req_valid_i && req_ready_o;
        if (req_acc) begin
            c.addr  = req_addr_i;
            c.wdata = req_wdata_i;
            c.write = req_write_i;
            c.tag   = req_tag_i;
            exp_cmd.push_back(c);
            acc_cyc = cyc;
            acc_cnt++;
        end
        if (mem_rsp_valid_i) begin
            if (pend_tags.size() != 0) begin
                r.tag  = pend_tags.pop_front();
                r.data = mem_rsp_rdata_i;
                exp_rsp.push_back(r);
            end else begin
                exp_err = 1;
            end
        end

        @(posedge clk_i);
        #1;
        cyc++;
        mem_rsp_valid_i = ret_next || spur;
        mem_rsp_rdata_i = {16{$urandom}};
        ret_next = 0;
        spur = 0;
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [TW-1:0] t,
                        input logic [DW-1:0] d);
        bit got = 0;
        req_valid_i = 1; req_write_i = w; req_addr_i = a; req_tag_i = t; req_wdata_i = d;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            got = req_acc;
        end
        req_valid_i = 0;
        chk("send_accept", got, 1);
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        req_valid_i = 0; mem_cmd_ready_i = 1; rsp_ready_i = 1;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (exp_cmd.size() == 0) && (exp_rsp.size() == 0) && (pend_tags.size() == 0)
                   && !ret_next && !mem_rsp_valid_i && (inflight == 0);
        end
        chk("drain_done", done, 1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_cmd_valid"}, mem_cmd_valid_o, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid_o, 0);
        chk({pfx, "_err"}, err_unexp_rsp_o, 0);
        chk({pfx, "_qcount"}, queue_count_o, 0);
        chk({pfx, "_inflight"}, rd_inflight_o, 0);
        chk({pfx, "_cmd_addr"}, mem_cmd_addr_o, 0);
        chk({pfx, "_cmd_wdata"}, mem_cmd_wdata_o, 0);
        chk({pfx, "_cmd_write"}, mem_cmd_write_o, 0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata_o, 0);
        chk({pfx, "_rsp_tag"}, rsp_tag_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a5;
        int c0, a0;
        a5 = {64{8'hA5}};

        // Reset state
        repeat (3) @(posedge clk_i);
        #2;
        chk_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        chk("rst_release_ready", req_ready_o, 1);

        // Single write then read, 3-cycle client-to-client latency
        mem_cmd_ready_i = 1; rsp_ready_i = 1;
        send(1, 32'h40, 4'd3, a5);
        repeat (4) tick();
        chk("write_no_rsp", rsp_cnt, 0);
        send(0, 32'h40, 4'd3, '0);
        for (int i = 0; i < 10 && rsp_cnt == 0; i++) tick();
        chk("read_latency", last_rsp_cyc - acc_cyc, 3);
        chk("read_tag", last_rsp_tag, 3);
        drain(50);

        // Eight back-to-back requests with the controller stalled
        mem_cmd_ready_i = 0;
        for (int i = 0; i < 8; i++) send(1, 32'h100 + i, 4'(i), {16{$urandom}});
        chk("full_count", queue_count_o, 8);
        chk("full_ready", req_ready_o, 0);
        a0 = acc_cnt;
        req_valid_i = 1; req_write_i = 1; req_addr_i = 32'h900; req_tag_i = 4'd8;
        req_wdata_i = {16{$urandom}};
        repeat (2) tick();
        chk("ninth_held", acc_cnt - a0, 0);
        mem_cmd_ready_i = 1;
        c0 = cmd_cnt;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req_acc) req_valid_i = 0;
        end
        chk("drain_rate", cmd_cnt - c0, 8);
        chk("ninth_accepted", acc_cnt - a0, 1);
        drain(50);

        // Six reads against four credits, client not accepting
        rsp_ready_i = 0;
        for (int i = 0; i < 6; i++) send(0, 32'h200 + 64 * i, 4'(i), '0);
        repeat (5) tick();
        chk("credit_inflight", rd_inflight_o, 4);
        chk("credit_blocked", mem_cmd_valid_o, 0);
        chk("credit_queued", queue_count_o, 2);
        seen_tags.delete();
        drain(60);
        chk("six_count", seen_tags.size(), 6);
        for (int i = 0; i < 6 && i < seen_tags.size(); i++) chk("six_order", seen_tags[i], i);

        // Blocked read stalls the write behind it
        rsp_ready_i = 0;
        for (int i = 0; i < 4; i++) send(0, 32'h300 + i, 4'(12 + i), '0);
        send(0, 32'h400, 4'd1, '0);
        send(1, 32'h404, 4'd7, {16{$urandom}});
        send(0, 32'h408, 4'd2, '0);
        repeat (3) tick();
        chk("block_count", queue_count_o, 3);
        chk("block_valid", mem_cmd_valid_o, 0);
        chk("block_inflight", rd_inflight_o, 4);
        seen_tags.delete();
        drain(60);
        chk("block_nrsp", seen_tags.size(), 6);
        if (seen_tags.size() == 6) begin
            chk("block_tag4", seen_tags[4], 1);
            chk("block_tag5", seen_tags[5], 2);
        end

        // Spurious controller response
        c0 = rsp_cnt;
        spur = 1;
        repeat (3) tick();
        chk("spur_err", err_unexp_rsp_o, 1);
        repeat (5) tick();
        chk("spur_sticky", err_unexp_rsp_o, 1);
        chk("spur_no_rsp", rsp_cnt - c0, 0);

        // Asynchronous reset with work queued and reads in flight
        mem_cmd_ready_i = 1; rsp_ready_i = 0;
        send(0, 32'h500, 4'd4, '0);
        send(0, 32'h540, 4'd5, '0);
        repeat (3) tick();
        mem_cmd_ready_i = 0;
        for (int i = 0; i < 3; i++) send(1, 32'h600 + i, 4'(9 + i), {16{$urandom}});
        chk("pre_rst_count", queue_count_o, 3);
        chk("pre_rst_inflight", rd_inflight_o, 2);
        #2;
        rst_ni = 0;
        #1;
        chk_reset_outputs("async");
        exp_cmd.delete(); pend_tags.delete(); exp_rsp.delete();
        inflight = 0; exp_err = 0; ret_next = 0; mem_rsp_valid_i = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        chk("post_rst_count", queue_count_o, 0);
        chk("post_rst_inflight", rd_inflight_o, 0);
        chk("post_rst_ready", req_ready_o, 1);
        chk("post_rst_err", err_unexp_rsp_o, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            req_valid_i     = ($urandom_range(0, 2) != 0);
            req_write_i     = $urandom_range(0, 1);
            req_addr_i      = $urandom;
            req_tag_i       = 4'($urandom);
            req_wdata_i     = {16{$urandom}};
            mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i     = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
